// File: rtl/imem_load_arbiter_if.sv
// imem_load_arbiter_if: bundles both loader request channels and the instruction-memory write port.
//   master: drives requester valid/addr/wdata/be; sees ready, mem_*, cpu_hold, owner
//   slave : the arbiter; drives ready, mem_*, cpu_hold, owner
interface imem_load_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    logic                  req0_valid;
    logic                  req0_ready;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata;
    logic [BE_WIDTH-1:0]   req0_be;
    logic                  req1_valid;
    logic                  req1_ready;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata;
    logic [BE_WIDTH-1:0]   req1_be;
    logic                  mem_en;
    logic [BE_WIDTH-1:0]   mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  cpu_hold;
    logic [1:0]            owner;
    modport master (
        output req0_valid, req0_addr, req0_wdata, req0_be,
        output req1_valid, req1_addr, req1_wdata, req1_be,
        input  req0_ready, req1_ready,
        input  mem_en, mem_we, mem_addr, mem_wdata, cpu_hold, owner
    );
    modport slave (
        input  req0_valid, req0_addr, req0_wdata, req0_be,
        input  req1_valid, req1_addr, req1_wdata, req1_be,
        output req0_ready, req1_ready,
        output mem_en, mem_we, mem_addr, mem_wdata, cpu_hold, owner
    );
endinterface

// File: rtl/imem_load_arbiter.sv
// imem_load_arbiter: sticky round-robin owner of the instruction-memory write port with CPU hold.
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (slave)  : two loader request channels, registered memory write port,
//                  cpu_hold (held until QUIET_CYCLES after the last byte-enabled beat),
//                  owner (00 none, 01 req0, 10 req1)
module imem_load_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int GAP_CYCLES   = 16,
    parameter int QUIET_CYCLES = 134217727
) (
    input logic                i_clk,
    input logic                i_rst,
    imem_load_arbiter_if.slave bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [QW-1:0] QUIET_LOAD = QW'(QUIET_CYCLES);
    // Encoding doubles as the o_owner value.
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
    state_t                state_q, state_d;
    logic [7:0]            gap_q, gap_d;
    logic                  ptr_q, ptr_d;
    logic                  mem_en_q, mem_en_d;
    logic [BE_WIDTH-1:0]   mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [QW-1:0]         quiet_q, quiet_d;
    logic                  hold_q, hold_d;
    logic                  owner_valid, other_valid;
    logic                  xfer0, xfer1;
    logic [BE_WIDTH-1:0]   xfer_be;
    // Ownership: ptr_q names the requester favoured on a tie in IDLE.
    always_comb begin
        state_d     = state_q;
        gap_d       = gap_q;
        ptr_d       = ptr_q;
        owner_valid = (state_q == OWN0) ? bus.req0_valid : bus.req1_valid;
        other_valid = (state_q == OWN0) ? bus.req1_valid : bus.req0_valid;
        case (state_q)
            IDLE: begin
                gap_d = '0;
                if (bus.req0_valid && bus.req1_valid) state_d = ptr_q ? OWN1 : OWN0;
                else if (bus.req0_valid) state_d = OWN0;
                else if (bus.req1_valid) state_d = OWN1;
            end
            OWN0, OWN1: begin
                if (owner_valid) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    // This idle cycle is the GAP_CYCLES-th in a row: hand over.
                    gap_d   = '0;
                    ptr_d   = (state_q == OWN0);
                    state_d = !other_valid ? IDLE : (state_q == OWN0) ? OWN1 : OWN0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // Registered write port and quiet-time hold.
    always_comb begin
        xfer0       = (state_q == OWN0) && bus.req0_valid;
        xfer1       = (state_q == OWN1) && bus.req1_valid;
        xfer_be     = xfer0 ? bus.req0_be : xfer1 ? bus.req1_be : '0;
        mem_en_d    = xfer0 || xfer1;
        mem_we_d    = xfer_be;
        mem_addr_d  = xfer0 ? bus.req0_addr : xfer1 ? bus.req1_addr : mem_addr_q;
        mem_wdata_d = xfer0 ? bus.req0_wdata : xfer1 ? bus.req1_wdata : mem_wdata_q;
        quiet_d     = (|xfer_be) ? QUIET_LOAD : (quiet_q != '0) ? quiet_q - QW'(1) : quiet_q;
        hold_d      = (quiet_d != '0);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            gap_q       <= '0;
            ptr_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            quiet_q     <= '0;
            hold_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gap_q       <= gap_d;
            ptr_q       <= ptr_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            quiet_q     <= quiet_d;
            hold_q      <= hold_d;
        end
    end
    assign bus.req0_ready = (state_q == OWN0);
    assign bus.req1_ready = (state_q == OWN1);
    assign bus.mem_en     = mem_en_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.owner      = state_q;
endmodule

// File: tb/tb_imem_load_arbiter.sv
// tb_imem_load_arbiter: directed stimulus, per-cycle model comparison plus literal checkpoints.
module tb_imem_load_arbiter;
    localparam int AW = 16, DW = 32, BW = 4, GAP = 4, QUIET = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0, bad = 0;
    bit   chk_en = 0;
    int   lat;
    always #5 clk = ~clk;
    imem_load_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    imem_load_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GAP_CYCLES(GAP), .QUIET_CYCLES(QUIET)
    ) dut (
        .i_clk(clk), .i_rst(rst), .bus(bus)
    );
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Model: owner 0 none / 1 req0 / 2 req1, idle-run length, favoured requester, quiet cycles left.
    int              m_owner = 0, m_idle = 0, m_fav = 0, m_quiet = 0;
    logic            m_en = 1'b0;
    logic [BW-1:0]   m_we = '0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_data = '0;
    bit              v0, v1, x0, x1, ov, tv;
    always @(posedge clk) begin
        if (rst) begin
            m_owner = 0; m_idle = 0; m_fav = 0; m_quiet = 0;
            m_en = 1'b0; m_we = '0; m_addr = '0; m_data = '0;
        end else begin
            v0 = (bus.req0_valid === 1'b1);
            v1 = (bus.req1_valid === 1'b1);
            x0 = (m_owner == 1) && v0;
            x1 = (m_owner == 2) && v1;
            m_en = x0 || x1;
            m_we = x0 ? bus.req0_be : x1 ? bus.req1_be : '0;
            if (x0) begin m_addr = bus.req0_addr; m_data = bus.req0_wdata; end
            if (x1) begin m_addr = bus.req1_addr; m_data = bus.req1_wdata; end
            if (m_we != '0) m_quiet = QUIET;
            else if (m_quiet > 0) m_quiet--;
            if (m_owner == 0) begin
                m_idle = 0;
                if (v0 && v1) m_owner = m_fav + 1;
                else if (v0) m_owner = 1;
                else if (v1) m_owner = 2;
            end else begin
                ov = (m_owner == 1) ? v0 : v1;
                tv = (m_owner == 1) ? v1 : v0;
                if (ov) m_idle = 0;
                else begin
                    m_idle++;
                    if (m_idle == GAP) begin
                        m_fav   = (m_owner == 1) ? 1 : 0;
                        m_owner = tv ? 3 - m_owner : 0;
                        m_idle  = 0;
                    end
                end
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            check("owner", bus.owner, 64'(m_owner));
            check("ready0", bus.req0_ready, m_owner == 1);
            check("ready1", bus.req1_ready, m_owner == 2);
            check("mem_en", bus.mem_en, m_en);
            check("mem_we", bus.mem_we, m_we);
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_wdata", bus.mem_wdata, m_data);
            check("cpu_hold", bus.cpu_hold, m_quiet > 0);
        end
    end
    // Holds valid until the arbiter accepts; lat = edges until the accepting edge.
    task automatic beat(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] b, output int n);
        logic acc;
        if (p == 0) begin
            bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_be = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_be = b;
        end
        n = 0;
        acc = 1'b0;
        while (acc !== 1'b1 && n < 20) begin
            acc = (p == 0) ? bus.req0_ready : bus.req1_ready;
            tick();
            n++;
        end
        if (acc !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: req%0d got no ready within %0d cycles", p, n);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask
    initial begin
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0; bus.req0_be = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0; bus.req1_be = '0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        chk_en = 1;
        check("rst_owner", bus.owner, 0);
        check("rst_en", bus.mem_en, 0);
        check("rst_hold", bus.cpu_hold, 0);
        repeat (5) tick();
        check("idle_owner", bus.owner, 0);
        // Single write from req0.
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0010; bus.req0_wdata = 32'hDEADBEEF; bus.req0_be = 4'hF;
        tick();
        check("grant_owner", bus.owner, 2'b01);
        check("grant_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        check("w0_en", bus.mem_en, 1);
        check("w0_we", bus.mem_we, 4'hF);
        check("w0_addr", bus.mem_addr, 16'h0010);
        check("w0_data", bus.mem_wdata, 32'hDEADBEEF);
        check("w0_hold", bus.cpu_hold, 1);
        tick();
        check("w0_pulse", bus.mem_en, 0);
        repeat (6) begin tick(); check("hold_high", bus.cpu_hold, 1); end
        tick();
        check("hold_fall", bus.cpu_hold, 0);
        check("released", bus.owner, 0);
        // Tie after reset: req0 wins, req1 waits out the gap.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_addr = 16'h0100; bus.req0_wdata = 32'hA0; bus.req0_be = 4'hF;
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h0200; bus.req1_wdata = 32'hB0; bus.req1_be = 4'h3;
        tick();
        check("tie_owner", bus.owner, 2'b01);
        for (int i = 0; i < 3; i++) begin
            bus.req0_addr = 16'(16'h0100 + i);
            bus.req0_wdata = 32'(32'hA0 + i);
            tick();
            check("stream_addr", bus.mem_addr, 16'(16'h0100 + i));
            check("stream_r1", bus.req1_ready, 0);
        end
        bus.req0_valid = 1'b0;
        repeat (3) begin tick(); check("gap_owner", bus.owner, 2'b01); end
        tick();
        check("switch_owner", bus.owner, 2'b10);
        check("switch_r1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        check("r1_en", bus.mem_en, 1);
        check("r1_addr", bus.mem_addr, 16'h0200);
        check("r1_we", bus.mem_we, 4'h3);
        // Zero byte-enable beats from req1.
        rst = 1'b1; tick(); rst = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h0300; bus.req1_wdata = 32'h5; bus.req1_be = 4'h0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.req1_addr = 16'(16'h0300 + i);
            tick();
            check("be0_en", bus.mem_en, 1);
            check("be0_we", bus.mem_we, 0);
            check("be0_hold", bus.cpu_hold, 0);
        end
        bus.req1_valid = 1'b0;
        // Byte-enabled beats every 7 cycles keep the hold up.
        beat(1, 16'h0400, 32'h11, 4'hF, lat);
        check("sp_lat0", lat, 1);
        for (int k = 0; k < 2; k++) begin
            repeat (5) begin tick(); check("sp_hold", bus.cpu_hold, 1); end
            beat(1, 16'(16'h0401 + k), 32'h12, 4'hF, lat);
            check("sp_lat", lat, 2);
            check("sp_hold_b", bus.cpu_hold, 1);
        end
        repeat (7) begin tick(); check("sp_tail", bus.cpu_hold, 1); end
        tick();
        check("sp_fall", bus.cpu_hold, 0);
        // Reset while OWN1 with hold set drops the pending beat.
        beat(1, 16'h0500, 32'h22, 4'hF, lat);
        check("pre_rst_owner", bus.owner, 2'b10);
        check("pre_rst_hold", bus.cpu_hold, 1);
        bus.req1_valid = 1'b1; bus.req1_addr = 16'h3333; bus.req1_be = 4'hF;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req1_valid = 1'b0;
        check("mr_owner", bus.owner, 0);
        check("mr_hold", bus.cpu_hold, 0);
        check("mr_en", bus.mem_en, 0);
        check("mr_addr", bus.mem_addr, 0);
        repeat (3) tick();
        check("mr_quiet", bus.mem_en, 0);
        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
